eth_led_indicator: RTL



---
 rtl/eth_led_indicator.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/eth_led_indicator.sv
// Multi-channel status LED driver: per-channel off / on / shared heartbeat / stretched activity.
// Optional build macro ETH_LED_INVERT_EN inverts every led bit (reset value included) for active-low boards.
module eth_led_indicator #(
    parameter int          NUM_CH            = 4,
    parameter int          CNT_W             = 32,
    parameter logic [31:0] BLINK_HALF_CYCLES = 32'h1FF_FFFF,
    parameter int          STRETCH_CYCLES    = 6_250_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     act_pulse,
    input  logic [2*NUM_CH-1:0]   mode,
    output logic [NUM_CH-1:0]     led,
    output logic                  hb
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } act_st_e;

`ifdef ETH_LED_INVERT_EN
    localparam logic INV_C = 1'b1;
`else
    localparam logic INV_C = 1'b0;
`endif

    localparam logic [CNT_W-1:0] HB_TC_C  = CNT_W'(BLINK_HALF_CYCLES);
    localparam logic [CNT_W-1:0] STR_LD_C = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]  hb_cnt_r;
    logic [CNT_W-1:0]  hb_cnt_nxt_s;
    logic              hb_r;
    logic              hb_nxt_s;

    act_st_e           st_r       [NUM_CH];
    act_st_e           st_nxt_s   [NUM_CH];
    logic [CNT_W-1:0]  cnt_r      [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt_s  [NUM_CH];
    logic [NUM_CH-1:0] pend_r;
    logic [NUM_CH-1:0] pend_nxt_s;
    logic [NUM_CH-1:0] led_r;
    logic [NUM_CH-1:0] led_nxt_s;

    // Shared heartbeat: terminal count clears the counter and flips the phase.
    always_comb begin
        hb_cnt_nxt_s = hb_cnt_r + ONE_C;
        hb_nxt_s     = hb_r;
        if (hb_cnt_r == HB_TC_C) begin
            hb_cnt_nxt_s = ZERO_C;
            hb_nxt_s     = ~hb_r;
        end else begin
            hb_cnt_nxt_s = hb_cnt_r + ONE_C;
            hb_nxt_s     = hb_r;
        end
    end

    // Activity FSM next state; channels not in activity mode are parked in IDLE.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            st_nxt_s[i]   = ST_IDLE;
            cnt_nxt_s[i]  = ZERO_C;
            pend_nxt_s[i] = 1'b0;
            if (mode[2*i +: 2] == 2'b11) begin
                case (st_r[i])
                    ST_IDLE: begin
                        if (act_pulse[i]) begin
                            st_nxt_s[i]  = ST_ON;
                            cnt_nxt_s[i] = STR_LD_C;
                        end else begin
                            st_nxt_s[i]  = ST_IDLE;
                        end
                    end
                    ST_ON: begin
                        pend_nxt_s[i] = pend_r[i] | act_pulse[i];
                        if (cnt_r[i] == ZERO_C) begin
                            st_nxt_s[i]  = ST_GAP;
                            cnt_nxt_s[i] = STR_LD_C;
                        end else begin
                            st_nxt_s[i]  = ST_ON;
                            cnt_nxt_s[i] = cnt_r[i] - ONE_C;
                        end
                    end
                    ST_GAP: begin
                        if (cnt_r[i] == ZERO_C) begin
                            // A pulse landing on the last gap cycle still counts.
                            if (pend_r[i] | act_pulse[i]) begin
                                st_nxt_s[i]  = ST_ON;
                                cnt_nxt_s[i] = STR_LD_C;
                            end else begin
                                st_nxt_s[i]  = ST_IDLE;
                            end
                        end else begin
                            st_nxt_s[i]   = ST_GAP;
                            cnt_nxt_s[i]  = cnt_r[i] - ONE_C;
                            pend_nxt_s[i] = pend_r[i] | act_pulse[i];
                        end
                    end
                    default: begin
                        st_nxt_s[i] = ST_IDLE;
                    end
                endcase
            end else begin
                st_nxt_s[i] = ST_IDLE;
            end
        end
    end

    // LED source select; uses next-cycle values so led and hb change on the same edge.
    always_comb begin
        led_nxt_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode[2*i +: 2])
                2'b00:   led_nxt_s[i] = INV_C;
                2'b01:   led_nxt_s[i] = ~INV_C;
                2'b10:   led_nxt_s[i] = hb_nxt_s ^ INV_C;
                2'b11:   led_nxt_s[i] = (st_nxt_s[i] == ST_ON) ^ INV_C;
                default: led_nxt_s[i] = INV_C;
            endcase
        end
    end

    // State registers; reset drops every pending event and forces the idle LED level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_cnt_r <= ZERO_C;
            hb_r     <= 1'b0;
            pend_r   <= {NUM_CH{1'b0}};
            led_r    <= {NUM_CH{INV_C}};
            for (int i = 0; i < NUM_CH; i++) begin
                st_r[i]  <= ST_IDLE;
                cnt_r[i] <= ZERO_C;
            end
        end else begin
            hb_cnt_r <= hb_cnt_nxt_s;
            hb_r     <= hb_nxt_s;
            pend_r   <= pend_nxt_s;
            led_r    <= led_nxt_s;
            for (int i = 0; i < NUM_CH; i++) begin
                st_r[i]  <= st_nxt_s[i];
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign led = led_r;
    assign hb  = hb_r;

endmodule
